// File: rtl/obb_integrator.sv
// Physics-step integrator feeding the OBB state register's parallel-load port.
// Snapshots state and impulses, then multiplies, updates velocity and position, and writes back.
module obb_integrator #(
  parameter int GRAVITY          = 0,
  parameter int ANGLE_HALF_RANGE = 402
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [23:0] imp_x_i,
  input  logic [23:0] imp_y_i,
  input  logic [15:0] ang_imp_i,
  input  logic [7:0]  width_i,
  input  logic [7:0]  height_i,
  input  logic [15:0] inertia_i,
  input  logic [15:0] inv_mass_i,
  input  logic [23:0] inv_inertia_i,
  input  logic [23:0] pos_x_i,
  input  logic [23:0] pos_y_i,
  input  logic [23:0] vel_x_i,
  input  logic [23:0] vel_y_i,
  input  logic [10:0] angle_i,
  input  logic [10:0] omega_i,
  output logic [7:0]  ld_width_o,
  output logic [7:0]  ld_height_o,
  output logic [15:0] ld_inertia_o,
  output logic [15:0] ld_inv_mass_o,
  output logic [23:0] ld_inv_inertia_o,
  output logic [23:0] ld_pos_x_o,
  output logic [23:0] ld_pos_y_o,
  output logic [23:0] ld_vel_x_o,
  output logic [23:0] ld_vel_y_o,
  output logic [10:0] ld_angle_o,
  output logic [10:0] ld_omega_o,
  output logic        load_o,
  output logic        busy_o,
  output logic        done_o
);

  // state   | meaning
  // S_IDLE  | waiting for start; snapshot taken on the accepting edge
  // S_MUL   | impulse * inverse mass / inertia products registered
  // S_VEL   | new linear and angular velocities registered
  // S_POS   | new position and wrapped angle written into the ld_* bus
  // S_WRITE | load/done strobe for one cycle
  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_VEL,
    S_POS,
    S_WRITE
  } state_t;

  localparam logic signed [48:0] GRAV_EXT = 49'(GRAVITY);
  localparam logic signed [11:0] ANG_HALF = 12'(ANGLE_HALF_RANGE);
  localparam logic signed [11:0] ANG_SPAN = 12'(2 * ANGLE_HALF_RANGE);

  state_t state_q, state_d;
  logic   snap_en;

  // Snapshot of register state and impulses
  logic [7:0]  width_q, height_q;
  logic [15:0] inertia_q, inv_mass_q;
  logic [23:0] inv_inertia_q;
  logic [23:0] pos_x_q, pos_y_q, vel_x_q, vel_y_q;
  logic [10:0] angle_q, omega_q;
  logic [23:0] imp_x_q, imp_y_q;
  logic [15:0] ang_imp_q;

  // Pipeline registers
  logic signed [47:0] prod_x_q, prod_y_q;
  logic signed [39:0] prod_w_q;
  logic [23:0]        vel_x_new_q, vel_y_new_q;
  logic [10:0]        omega_new_q;

  // Output bus registers
  logic [7:0]  ld_width_q, ld_height_q;
  logic [15:0] ld_inertia_q, ld_inv_mass_q;
  logic [23:0] ld_inv_inertia_q;
  logic [23:0] ld_pos_x_q, ld_pos_y_q, ld_vel_x_q, ld_vel_y_q;
  logic [10:0] ld_angle_q, ld_omega_q;

  // Combinational datapath
  logic signed [47:0] prod_x_d, prod_y_d;
  logic signed [39:0] prod_w_d;
  logic signed [48:0] sum_vx, sum_vy;
  logic signed [17:0] sum_w;
  logic signed [24:0] sum_px, sum_py;
  logic signed [11:0] ang_raw, ang_wrap;
  logic [23:0]        vel_x_d, vel_y_d, pos_x_d, pos_y_d;
  logic [10:0]        omega_d, angle_d;

  function automatic logic [23:0] sat24(input logic signed [48:0] v);
    if (v > 49'sd8388607) begin
      return 24'h7FFFFF;
    end else if (v < -49'sd8388608) begin
      return 24'h800000;
    end
    return v[23:0];
  endfunction

  function automatic logic [10:0] sat11(input logic signed [17:0] v);
    if (v > 18'sd1023) begin
      return 11'h3FF;
    end else if (v < -18'sd1024) begin
      return 11'h400;
    end
    return v[10:0];
  endfunction

  always_comb begin
    state_d = state_q;
    snap_en = 1'b0;
    load_o  = 1'b0;
    done_o  = 1'b0;
    busy_o  = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          snap_en = 1'b1;
          state_d = S_MUL;
        end
      end
      S_MUL:   state_d = S_VEL;
      S_VEL:   state_d = S_POS;
      S_POS:   state_d = S_WRITE;
      S_WRITE: begin
        load_o  = 1'b1;
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_o  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Inverse mass and inverse inertia are unsigned magnitudes; zero-extend before the signed multiply
  always_comb begin
    prod_x_d = $signed(imp_x_q) * $signed({1'b0, inv_mass_q});
    prod_y_d = $signed(imp_y_q) * $signed({1'b0, inv_mass_q});
    prod_w_d = $signed(ang_imp_q) * $signed({1'b0, inv_inertia_q});

    sum_vx  = {{25{vel_x_q[23]}}, vel_x_q} + {{15{prod_x_q[47]}}, prod_x_q[47:14]};
    sum_vy  = {{25{vel_y_q[23]}}, vel_y_q} + {{15{prod_y_q[47]}}, prod_y_q[47:14]} + GRAV_EXT;
    sum_w   = {{7{omega_q[10]}}, omega_q} + {prod_w_q[39], prod_w_q[39:23]};
    vel_x_d = sat24(sum_vx);
    vel_y_d = sat24(sum_vy);
    omega_d = sat11(sum_w);

    // Position uses the freshly updated velocity (semi-implicit Euler)
    sum_px  = {pos_x_q[23], pos_x_q} + {{4{vel_x_new_q[23]}}, vel_x_new_q[23:3]};
    sum_py  = {pos_y_q[23], pos_y_q} + {{4{vel_y_new_q[23]}}, vel_y_new_q[23:3]};
    pos_x_d = sat24(49'(sum_px));
    pos_y_d = sat24(49'(sum_py));

    ang_raw  = {angle_q[10], angle_q} + {omega_new_q[10], omega_new_q};
    ang_wrap = ang_raw;
    if (ang_raw > ANG_HALF) begin
      ang_wrap = ang_raw - ANG_SPAN;
    end else if (ang_raw < -ANG_HALF) begin
      ang_wrap = ang_raw + ANG_SPAN;
    end
    angle_d = ang_wrap[10:0];
  end

  logic unused_lsbs;
  assign unused_lsbs = ^{prod_x_q[13:0], prod_y_q[13:0], prod_w_q[22:0], ang_wrap[11]};

  always_ff @(posedge clk_i) begin
    if (snap_en) begin
      width_q       <= width_i;
      height_q      <= height_i;
      inertia_q     <= inertia_i;
      inv_mass_q    <= inv_mass_i;
      inv_inertia_q <= inv_inertia_i;
      pos_x_q       <= pos_x_i;
      pos_y_q       <= pos_y_i;
      vel_x_q       <= vel_x_i;
      vel_y_q       <= vel_y_i;
      angle_q       <= angle_i;
      omega_q       <= omega_i;
      imp_x_q       <= imp_x_i;
      imp_y_q       <= imp_y_i;
      ang_imp_q     <= ang_imp_i;
    end
    if (state_q == S_MUL) begin
      prod_x_q <= prod_x_d;
      prod_y_q <= prod_y_d;
      prod_w_q <= prod_w_d;
    end
    if (state_q == S_VEL) begin
      vel_x_new_q <= vel_x_d;
      vel_y_new_q <= vel_y_d;
      omega_new_q <= omega_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= S_IDLE;
      ld_width_q       <= '0;
      ld_height_q      <= '0;
      ld_inertia_q     <= '0;
      ld_inv_mass_q    <= '0;
      ld_inv_inertia_q <= '0;
      ld_pos_x_q       <= '0;
      ld_pos_y_q       <= '0;
      ld_vel_x_q       <= '0;
      ld_vel_y_q       <= '0;
      ld_angle_q       <= '0;
      ld_omega_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_POS) begin
        ld_width_q       <= width_q;
        ld_height_q      <= height_q;
        ld_inertia_q     <= inertia_q;
        ld_inv_mass_q    <= inv_mass_q;
        ld_inv_inertia_q <= inv_inertia_q;
        ld_pos_x_q       <= pos_x_d;
        ld_pos_y_q       <= pos_y_d;
        ld_vel_x_q       <= vel_x_new_q;
        ld_vel_y_q       <= vel_y_new_q;
        ld_angle_q       <= angle_d;
        ld_omega_q       <= omega_new_q;
      end
    end
  end

  assign ld_width_o       = ld_width_q;
  assign ld_height_o      = ld_height_q;
  assign ld_inertia_o     = ld_inertia_q;
  assign ld_inv_mass_o    = ld_inv_mass_q;
  assign ld_inv_inertia_o = ld_inv_inertia_q;
  assign ld_pos_x_o       = ld_pos_x_q;
  assign ld_pos_y_o       = ld_pos_y_q;
  assign ld_vel_x_o       = ld_vel_x_q;
  assign ld_vel_y_o       = ld_vel_y_q;
  assign ld_angle_o       = ld_angle_q;
  assign ld_omega_o       = ld_omega_q;

endmodule

// File: tb/tb_obb_integrator.sv
// Self-checking bench for obb_integrator: directed corner cases plus randomized steps
// against an arithmetic reference model; a second instance runs with GRAVITY=-100.
module tb_obb_integrator;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [23:0] imp_x, imp_y;
  logic [15:0] ang_imp;
  logic [7:0]  width, height;
  logic [15:0] inertia, inv_mass;
  logic [23:0] inv_inertia, pos_x, pos_y, vel_x, vel_y;
  logic [10:0] angle, omega;

  logic [7:0]  o0_width, o0_height, o1_width, o1_height;
  logic [15:0] o0_inertia, o0_inv_mass, o1_inertia, o1_inv_mass;
  logic [23:0] o0_inv_inertia, o0_pos_x, o0_pos_y, o0_vel_x, o0_vel_y;
  logic [23:0] o1_inv_inertia, o1_pos_x, o1_pos_y, o1_vel_x, o1_vel_y;
  logic [10:0] o0_angle, o0_omega, o1_angle, o1_omega;
  logic        o0_load, o0_busy, o0_done, o1_load, o1_busy, o1_done;

  int checks = 0;
  int errors = 0;

  // Values captured at the load strobe
  logic [7:0]  c0_width, c0_height;
  logic [15:0] c0_inertia, c0_inv_mass;
  logic [23:0] c0_inv_inertia, c0_pos_x, c0_pos_y, c0_vel_x, c0_vel_y, c1_pos_y, c1_vel_y;
  logic [10:0] c0_angle, c0_omega;
  logic        c0_done;
  int          lat, load_cnt, busy_cnt;

  always #5 clk = ~clk;

  obb_integrator #(.GRAVITY(0), .ANGLE_HALF_RANGE(402)) dut0 (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .imp_x_i(imp_x), .imp_y_i(imp_y), .ang_imp_i(ang_imp),
    .width_i(width), .height_i(height), .inertia_i(inertia), .inv_mass_i(inv_mass),
    .inv_inertia_i(inv_inertia), .pos_x_i(pos_x), .pos_y_i(pos_y),
    .vel_x_i(vel_x), .vel_y_i(vel_y), .angle_i(angle), .omega_i(omega),
    .ld_width_o(o0_width), .ld_height_o(o0_height), .ld_inertia_o(o0_inertia),
    .ld_inv_mass_o(o0_inv_mass), .ld_inv_inertia_o(o0_inv_inertia),
    .ld_pos_x_o(o0_pos_x), .ld_pos_y_o(o0_pos_y), .ld_vel_x_o(o0_vel_x),
    .ld_vel_y_o(o0_vel_y), .ld_angle_o(o0_angle), .ld_omega_o(o0_omega),
    .load_o(o0_load), .busy_o(o0_busy), .done_o(o0_done)
  );

  obb_integrator #(.GRAVITY(-100), .ANGLE_HALF_RANGE(402)) dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .imp_x_i(imp_x), .imp_y_i(imp_y), .ang_imp_i(ang_imp),
    .width_i(width), .height_i(height), .inertia_i(inertia), .inv_mass_i(inv_mass),
    .inv_inertia_i(inv_inertia), .pos_x_i(pos_x), .pos_y_i(pos_y),
    .vel_x_i(vel_x), .vel_y_i(vel_y), .angle_i(angle), .omega_i(omega),
    .ld_width_o(o1_width), .ld_height_o(o1_height), .ld_inertia_o(o1_inertia),
    .ld_inv_mass_o(o1_inv_mass), .ld_inv_inertia_o(o1_inv_inertia),
    .ld_pos_x_o(o1_pos_x), .ld_pos_y_o(o1_pos_y), .ld_vel_x_o(o1_vel_x),
    .ld_vel_y_o(o1_vel_y), .ld_angle_o(o1_angle), .ld_omega_o(o1_omega),
    .load_o(o1_load), .busy_o(o1_busy), .done_o(o1_done)
  );

  // Reference model: fixed-point physics step in plain 64-bit arithmetic
  function automatic longint sat(input longint v, input int bits);
    longint hi, lo;
    hi = (longint'(1) <<< (bits - 1)) - 1;
    lo = -(longint'(1) <<< (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model(input int grav, output logic [23:0] epx, output logic [23:0] epy,
                       output logic [23:0] evx, output logic [23:0] evy,
                       output logic [10:0] eang, output logic [10:0] eom);
    longint vx, vy, om, px, py, a;
    vx = sat(longint'($signed(vel_x)) + ((longint'($signed(imp_x)) * longint'(inv_mass)) >>> 14), 24);
    vy = sat(longint'($signed(vel_y)) + ((longint'($signed(imp_y)) * longint'(inv_mass)) >>> 14)
             + longint'(grav), 24);
    om = sat(longint'($signed(omega)) + ((longint'($signed(ang_imp)) * longint'(inv_inertia)) >>> 23), 11);
    px = sat(longint'($signed(pos_x)) + (vx >>> 3), 24);
    py = sat(longint'($signed(pos_y)) + (vy >>> 3), 24);
    a  = longint'($signed(angle)) + om;
    if (a > 402) a = a - 804;
    else if (a < -402) a = a + 804;
    epx  = px[23:0];
    epy  = py[23:0];
    evx  = vx[23:0];
    evy  = vy[23:0];
    eang = a[10:0];
    eom  = om[10:0];
  endtask

  task automatic clear_inputs();
    imp_x = '0; imp_y = '0; ang_imp = '0;
    width = '0; height = '0; inertia = '0; inv_mass = '0; inv_inertia = '0;
    pos_x = '0; pos_y = '0; vel_x = '0; vel_y = '0; angle = '0; omega = '0;
  endtask

  task automatic scramble();
    imp_x = 24'($urandom); imp_y = 24'($urandom); ang_imp = 16'($urandom);
    width = 8'($urandom); height = 8'($urandom); inertia = 16'($urandom);
    inv_mass = 16'($urandom); inv_inertia = 24'($urandom);
    pos_x = 24'($urandom); pos_y = 24'($urandom); vel_x = 24'($urandom);
    vel_y = 24'($urandom); angle = 11'($urandom); omega = 11'($urandom);
  endtask

  // One start pulse; inputs are scrambled right after the snapshot edge.
  // lat is the cycle (counting from the accepting edge) where load was seen, -1 if never.
  task automatic run_step();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    scramble();
    lat = -1; load_cnt = 0; busy_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      if (o0_busy) busy_cnt++;
      if (o0_load) begin
        load_cnt++;
        if (lat < 0) lat = c;
        c0_width = o0_width; c0_height = o0_height; c0_inertia = o0_inertia;
        c0_inv_mass = o0_inv_mass; c0_inv_inertia = o0_inv_inertia;
        c0_pos_x = o0_pos_x; c0_pos_y = o0_pos_y; c0_vel_x = o0_vel_x; c0_vel_y = o0_vel_y;
        c0_angle = o0_angle; c0_omega = o0_omega; c0_done = o0_done;
      end
      if (o1_load) begin
        c1_pos_y = o1_pos_y; c1_vel_y = o1_vel_y;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if ({o0_load, o0_busy, o0_done} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: load/busy/done=%b expected 000", {o0_load, o0_busy, o0_done});
    end
    checks++;
    if ({o0_pos_x, o0_vel_y, o0_width, o0_angle, o0_inv_inertia, o1_omega} !== '0) begin
      errors++; $display("FAIL reset_ld: pos_x=%h vel_y=%h width=%h angle=%h expected 0",
                         o0_pos_x, o0_vel_y, o0_width, o0_angle);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int loads;
    clear_inputs();
    pos_x = 24'(32 << 16); vel_x = 24'(1 << 19); width = 8'd7;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checks++;
    if (o0_busy !== 1'b1) begin
      errors++; $display("FAIL abort_busy_vel: busy=%b expected 1", o0_busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({o0_busy, o0_load} !== 2'b00) begin
      errors++; $display("FAIL abort_after_reset: busy/load=%b expected 00", {o0_busy, o0_load});
    end
    reset = 1'b0;
    loads = 0;
    repeat (6) begin
      @(negedge clk);
      if (o0_load) loads++;
    end
    checks++;
    if (loads !== 0 || o0_pos_x !== 24'h0) begin
      errors++; $display("FAIL abort_no_load: loads=%0d pos_x=%h expected 0 and 0", loads, o0_pos_x);
    end
  endtask

  task automatic test_latency();
    clear_inputs();
    pos_x = 24'(32 << 16); vel_x = 24'(1 << 19);
    width = 8'd20; height = 8'd12; inertia = 16'h1234; inv_mass = 16'h0800; inv_inertia = 24'h0ABCDE;
    run_step();
    checks++;
    if (lat !== 4 || load_cnt !== 1 || busy_cnt !== 4 || c0_done !== 1'b1) begin
      errors++; $display("FAIL latency: load_cycle=%0d loads=%0d busy_cycles=%0d done=%b expected 4 1 4 1",
                         lat, load_cnt, busy_cnt, c0_done);
    end
    checks++;
    if (c0_pos_x !== 24'(33 << 16) || c0_vel_x !== 24'(1 << 19)) begin
      errors++; $display("FAIL latency_pos: pos_x=%h vel_x=%h expected %h %h",
                         c0_pos_x, c0_vel_x, 24'(33 << 16), 24'(1 << 19));
    end
    checks++;
    if ({c0_width, c0_height, c0_inertia, c0_inv_mass, c0_inv_inertia} !==
        {8'd20, 8'd12, 16'h1234, 16'h0800, 24'h0ABCDE}) begin
      errors++; $display("FAIL passthrough: w=%h h=%h I=%h im=%h ii=%h expected 14 0c 1234 0800 0abcde",
                         c0_width, c0_height, c0_inertia, c0_inv_mass, c0_inv_inertia);
    end
  endtask

  task automatic test_impulse();
    clear_inputs();
    inv_mass = 16'(1 << 14); imp_x = 24'(1 << 19);
    run_step();
    checks++;
    if (lat !== 4 || c0_vel_x !== 24'(1 << 19) || c0_pos_x !== 24'(1 << 16)) begin
      errors++; $display("FAIL impulse: lat=%0d vel_x=%h pos_x=%h expected 4 %h %h",
                         lat, c0_vel_x, c0_pos_x, 24'(1 << 19), 24'(1 << 16));
    end
  endtask

  task automatic test_angle_wrap();
    logic [10:0] exp_a;
    clear_inputs();
    angle = 11'd400; omega = 11'd10;
    run_step();
    exp_a = 11'(-394);
    checks++;
    if (c0_angle !== exp_a || c0_omega !== 11'd10) begin
      errors++; $display("FAIL wrap_pos: angle=%0d omega=%0d expected -394 10",
                         $signed(c0_angle), $signed(c0_omega));
    end
    clear_inputs();
    angle = 11'(-400); omega = 11'(-10);
    run_step();
    checks++;
    if (c0_angle !== 11'd394) begin
      errors++; $display("FAIL wrap_neg: angle=%0d expected 394", $signed(c0_angle));
    end
  endtask

  task automatic test_saturation();
    clear_inputs();
    pos_x = 24'h7FFFF0; vel_x = 24'h7FFFFF;
    omega = 11'd1020; ang_imp = 16'h7FFF; inv_inertia = 24'hFFFFFF;
    run_step();
    checks++;
    if (c0_pos_x !== 24'h7FFFFF || c0_vel_x !== 24'h7FFFFF) begin
      errors++; $display("FAIL sat_pos: pos_x=%h vel_x=%h expected 7fffff 7fffff", c0_pos_x, c0_vel_x);
    end
    checks++;
    if (c0_omega !== 11'd1023) begin
      errors++; $display("FAIL sat_omega: omega=%0d expected 1023", $signed(c0_omega));
    end
    clear_inputs();
    vel_y = 24'h800000; imp_y = 24'h800000; inv_mass = 16'hFFFF;
    run_step();
    checks++;
    if (c0_vel_y !== 24'h800000) begin
      errors++; $display("FAIL sat_neg_vel: vel_y=%h expected 800000", c0_vel_y);
    end
  endtask

  task automatic test_start_while_busy();
    int loads;
    clear_inputs();
    vel_x = 24'(3 << 19);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b1;
    loads = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 2) start = 1'b0;
      if (o0_load) loads++;
      @(negedge clk);
    end
    checks++;
    if (loads !== 1) begin
      errors++; $display("FAIL start_while_busy: loads=%0d expected 1", loads);
    end
  endtask

  task automatic test_gravity();
    clear_inputs();
    run_step();
    checks++;
    if (c1_vel_y !== 24'(-100) || c1_pos_y !== 24'(-13) || c0_vel_y !== 24'h0) begin
      errors++; $display("FAIL gravity: g_vel_y=%0d g_pos_y=%0d nog_vel_y=%0d expected -100 -13 0",
                         $signed(c1_vel_y), $signed(c1_pos_y), $signed(c0_vel_y));
    end
  endtask

  task automatic test_back_to_back();
    int first, second, loads;
    clear_inputs();
    pos_x = 24'(5 << 16);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    first = -1; second = -1; loads = 0;
    for (int c = 1; c <= 10; c++) begin
      if (o0_load) begin
        loads++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (loads !== 2 || first !== 4 || second !== 9) begin
      errors++; $display("FAIL back_to_back: loads=%0d at %0d,%0d expected 2 at 4,9", loads, first, second);
    end
  endtask

  task automatic test_random();
    logic [23:0] epx, epy, evx, evy, gpx, gpy, gvx, gvy;
    logic [10:0] eang, eom, gang, gom;
    for (int i = 0; i < 40; i++) begin
      scramble();
      angle = 11'($urandom_range(0, 804) - 402);
      if (i % 2 == 0) begin
        imp_x = 24'($signed(imp_x) >>> 6);
        imp_y = 24'($signed(imp_y) >>> 6);
        vel_x = 24'($signed(vel_x) >>> 4);
        vel_y = 24'($signed(vel_y) >>> 4);
        inv_mass = inv_mass >> 2;
        ang_imp = 16'($signed(ang_imp) >>> 8);
        omega = 11'($signed(omega) >>> 3);
      end
      model(0, epx, epy, evx, evy, eang, eom);
      model(-100, gpx, gpy, gvx, gvy, gang, gom);
      run_step();
      checks++;
      if (lat !== 4 || c0_pos_x !== epx || c0_pos_y !== epy || c0_vel_x !== evx || c0_vel_y !== evy) begin
        errors++; $display("FAIL rand_lin[%0d]: lat=%0d px=%h py=%h vx=%h vy=%h expected 4 %h %h %h %h",
                           i, lat, c0_pos_x, c0_pos_y, c0_vel_x, c0_vel_y, epx, epy, evx, evy);
      end
      checks++;
      if (c0_angle !== eang || c0_omega !== eom) begin
        errors++; $display("FAIL rand_ang[%0d]: angle=%0d omega=%0d expected %0d %0d",
                           i, $signed(c0_angle), $signed(c0_omega), $signed(eang), $signed(eom));
      end
      checks++;
      if (c1_vel_y !== gvy || c1_pos_y !== gpy) begin
        errors++; $display("FAIL rand_grav[%0d]: vy=%h py=%h expected %h %h", i, c1_vel_y, c1_pos_y, gvy, gpy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_abort();
    test_latency();
    test_impulse();
    test_angle_wrap();
    test_saturation();
    test_start_while_busy();
    test_gravity();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/obb_integrator.md
Name: obb_integrator

Overview:
- Writer side of the OBB state register's parallel-load interface.
- On each `start` (one per physics step), it snapshots the register's current outputs and applies the pending linear and angular impulses plus gravity.
- It then integrates velocity into position and angular rate into angle (semi-implicit Euler, dt = 1 step).
- It drives the register's `ld_*` bus and pulses `load` for exactly one cycle. It sits between the collision/impulse logic and the OBB register.

Parameters:
- GRAVITY, 0, signed raw LSBs added to vel_y each step (velocity format, 2^19 = 1 px/step).
- ANGLE_HALF_RANGE, 402, pi in angle LSBs (2^7 scale); angle wraps to [-402, +402].

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  request one integration step; accepted only in IDLE
- imp_x, imp_y  in  24 signed  linear impulse, velocity format before mass scaling
- ang_imp  in  16 signed  angular impulse
- width, height  in  8  current register state
- inertia, inv_mass  in  16  current state; inv_mass is Q2.14
- inv_inertia  in  24  current state, 2^23 scale
- pos_x, pos_y  in  24 signed  current state, 2^16 scale
- vel_x, vel_y  in  24 signed  current state, 2^19 scale
- angle, omega  in  11 signed  current state, 2^7 scale
- ld_width, ld_height, ld_inertia, ld_inv_mass, ld_inv_inertia, ld_pos_x, ld_pos_y, ld_vel_x, ld_vel_y, ld_angle, ld_omega  out  same widths as the matching inputs  load data
- load  out  1  one-cycle write strobe to the register
- busy  out  1  step in progress
- done  out  1  one-cycle completion pulse, coincident with load

Behaviour:
- Reset: state=IDLE; load=0, busy=0, done=0; all ld_* = 0. Reset mid-step aborts the step with no load pulse.
- States: IDLE -> MUL -> VEL -> POS -> WRITE -> IDLE.
  - IDLE: on the edge where start=1, snapshot all state inputs and impulse inputs. Go to MUL.
  - MUL: register products. px = imp_x*inv_mass (48-bit signed), py = imp_y*inv_mass, pw = ang_imp*inv_inertia (40-bit signed).
  - VEL:
    - v_x' = sat24(vel_x + (px>>>14)).
    - v_y' = sat24(vel_y + (py>>>14) + GRAVITY).
    - w' = sat11(omega + (pw>>>23)).
  - POS:
    - p_x' = sat24(pos_x + (v_x'>>>3)); p_y' likewise.
    - a_raw = angle + w' (12-bit).
    - If a_raw > ANGLE_HALF_RANGE then a' = a_raw - 2*ANGLE_HALF_RANGE; if a_raw < -ANGLE_HALF_RANGE then a' = a_raw + 2*ANGLE_HALF_RANGE; otherwise a' = a_raw.
  - WRITE: load=1 and done=1 for this cycle only; ld_* hold the results. Return to IDLE.
- Latency: with start accepted at edge N, busy=1 during cycles N+1..N+4 and load/done=1 during cycle N+4.
- Passthrough: width, height, inertia, inv_mass and inv_inertia are loaded unchanged from the snapshot.
- Input stability: state inputs and impulses are ignored after the snapshot edge, so they may change freely while busy.
- start while busy is ignored, not queued. start high continuously yields back-to-back steps separated by one IDLE cycle.
- sat24/sat11 clamp to the signed range of the target width: 24-bit clamps to [0x800000, 0x7FFFFF]; 11-bit clamps to [-1024, 1023]. Shifts are arithmetic.
- ld_* hold their last written values in IDLE; they are not cleared.

Test Plan:
- Reset -> load=busy=done=0, all ld_*=0; assert reset during VEL of a running step -> no load pulse, busy=0 the next cycle.
- pos_x=32<<16, vel_x=1<<19, no impulses, GRAVITY=0, start at edge N -> load=1 only at cycle N+4; ld_pos_x=33<<16; ld_vel_x and the passthrough fields unchanged.
- inv_mass=1<<14, imp_x=1<<19, vel_x=0, pos_x=0 -> ld_vel_x=1<<19, ld_pos_x=1<<16 (new velocity used).
- angle=400, omega=10 -> ld_angle=-394; angle=-400, omega=-10 -> ld_angle=394.
- pos_x=0x7FFFF0, vel_x=0x7FFFFF -> ld_pos_x=0x7FFFFF; omega=1020, large positive ang_imp -> ld_omega=1023.
- Pulse start again at N+2 -> exactly one load; GRAVITY=-100, vel_y=0 -> ld_vel_y=-100.
